// File: rtl/port_input.sv
// port_input: synchronised switch and debounced button input port.
// Optional macro PORT_INPUT_EVENT_COUNT_EN adds a press counter at +3.
module port_input #(
    parameter int WORD_SIZE = 16,
    parameter int DEBOUNCE_BITS = 16,
    parameter logic [WORD_SIZE-1:0] BASE_ADDR = 16'h0010
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           sw,
    input  logic [3:0]           btn,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic [WORD_SIZE-1:0] portval,
    input  logic                 portget,
    input  logic                 portset,
    output logic [WORD_SIZE-1:0] portout,
    output logic [3:0]           btn_level
);

    localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE = DEBOUNCE_BITS'(1);

    logic [7:0]               r_sw_s1;
    logic [7:0]               r_sw_s2;
    logic [3:0]               r_btn_s1;
    logic [3:0]               r_btn_s2;
    logic [DEBOUNCE_BITS-1:0] r_cnt [4];
    logic [3:0]               r_level;
    logic [3:0]               r_flag;
    logic [WORD_SIZE-1:0]     r_out;

    logic [WORD_SIZE-1:0]     w_off;
    logic                     w_hit;
    logic                     w_rd;
    logic                     w_rd_flag;
    logic                     w_wr_flag;
    logic [3:0]               w_toggle;
    logic [3:0]               w_rise;
    logic [3:0]               w_clr;
    logic [WORD_SIZE-1:0]     w_rdata;
    logic [WORD_SIZE-1:0]     w_evt_word;
    logic                     w_unused;

    // Full-width decode: wrap-around makes addresses below BASE miss.
    assign w_off     = portaddr - BASE_ADDR;
    assign w_hit     = (w_off < WORD_SIZE'(4));
    assign w_rd      = portget & w_hit;
    assign w_rd_flag = w_rd & (w_off[1:0] == 2'd2);
    assign w_wr_flag = portset & ~portget & w_hit
                     & (w_off[1:0] == 2'd2);
    assign w_unused  = ^portval[WORD_SIZE-1:4];

    // Two-flop synchronisers on every switch and button pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
        end else begin
            r_sw_s1  <= sw;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= btn;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // A level flips once the input has differed for a full window
    always_comb begin
        w_toggle = '0;
        for (int i = 0; i < 4; i++) begin
            w_toggle[i] = (r_btn_s2[i] != r_level[i]) && (&r_cnt[i]);
        end
    end

    assign w_rise = w_toggle & ~r_level;

    // Read of +2 clears what it reports; a write clears by mask
    always_comb begin
        w_clr = '0;
        if (w_rd_flag) begin
            w_clr = r_flag;
        end else if (w_wr_flag) begin
            w_clr = portval[3:0];
        end
    end

    // Debounce counters, levels and sticky press flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
            r_level <= '0;
            r_flag  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_btn_s2[i] == r_level[i] || w_toggle[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
            r_level <= r_level ^ w_toggle;
            r_flag  <= (r_flag & ~w_clr) | w_rise;
        end
    end

`ifdef PORT_INPUT_EVENT_COUNT_EN
    logic [7:0] r_evt;
    logic [8:0] w_evt_sum;
    logic       w_rd_evt;

    assign w_rd_evt  = w_rd & (w_off[1:0] == 2'd3);
    assign w_evt_sum = (w_rd_evt ? 9'd0 : {1'b0, r_evt})
                     + {8'd0, w_rise[0]} + {8'd0, w_rise[1]}
                     + {8'd0, w_rise[2]} + {8'd0, w_rise[3]};
    assign w_evt_word = WORD_SIZE'(r_evt);

    // Saturating press counter, read-to-clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt <= '0;
        end else begin
            r_evt <= (w_evt_sum > 9'd255) ? 8'hFF : w_evt_sum[7:0];
        end
    end
`else
    assign w_evt_word = '0;
`endif

    // Read data select
    always_comb begin
        w_rdata = '0;
        case (w_off[1:0])
            2'd0:    w_rdata = WORD_SIZE'(r_sw_s2);
            2'd1:    w_rdata = WORD_SIZE'(r_level);
            2'd2:    w_rdata = WORD_SIZE'(r_flag);
            default: w_rdata = w_evt_word;
        endcase
    end

    // Registered read data, held until the next serviced read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (w_rd) begin
            r_out <= w_rdata;
        end
    end

    assign portout   = r_out;
    assign btn_level = r_level;

endmodule

// File: tb/tb_port_input.sv
// tb_port_input: random and directed checks of port_input against
// a sample-window model of the debounced input port.
module tb_port_input;

    localparam int DB  = 2;
    localparam int WIN = 1 << DB;
    localparam logic [15:0] BASE = 16'h0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sw = '0;
    logic [3:0]  btn = '0;
    logic [15:0] portaddr = '0;
    logic [15:0] portval = '0;
    logic        portget = 1'b0;
    logic        portset = 1'b0;
    logic [15:0] portout;
    logic [3:0]  btn_level;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    port_input #(
        .WORD_SIZE(16),
        .DEBOUNCE_BITS(DB),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .btn(btn),
        .portaddr(portaddr),
        .portval(portval),
        .portget(portget),
        .portset(portset),
        .portout(portout),
        .btn_level(btn_level)
    );

    // Model: pins reach the debouncer two edges late; a level flips
    // when the last WIN samples all disagree with it.
    logic [7:0]  m_sw1, m_sw2;
    logic [3:0]  m_b1, m_b2;
    logic [3:0]  m_win [WIN];
    logic [3:0]  m_lvl, m_flag;
    logic [15:0] m_out;
    int          m_cnt;

    always @(posedge clk or posedge rst) begin : model
        int          off;
        logic [15:0] rd;
        logic [3:0]  nl, rise, clr;
        logic        diff;
        if (rst) begin
            m_sw1 = '0; m_sw2 = '0; m_b1 = '0; m_b2 = '0;
            for (int k = 0; k < WIN; k++) m_win[k] = '0;
            m_lvl = '0; m_flag = '0; m_out = '0; m_cnt = 0;
        end else begin
            off = int'(portaddr) - int'(BASE);
            case (off)
                0: rd = {8'h00, m_sw2};
                1: rd = {12'h000, m_lvl};
                2: rd = {12'h000, m_flag};
`ifdef PORT_INPUT_EVENT_COUNT_EN
                3: rd = 16'(m_cnt);
`endif
                default: rd = 16'h0000;
            endcase
            for (int k = WIN - 1; k > 0; k--) m_win[k] = m_win[k-1];
            m_win[0] = m_b2;
            nl = m_lvl;
            for (int i = 0; i < 4; i++) begin
                diff = 1'b1;
                for (int k = 0; k < WIN; k++)
                    if (m_win[k][i] == m_lvl[i]) diff = 1'b0;
                if (diff) nl[i] = ~m_lvl[i];
            end
            rise = nl & ~m_lvl;
            clr = '0;
            if (portget && off == 2) clr = m_flag;
            else if (portset && off == 2) clr = portval[3:0];
            if (portget && off == 3) m_cnt = 0;
            m_cnt = m_cnt + $countones(rise);
            if (m_cnt > 255) m_cnt = 255;
            if (portget && off >= 0 && off < 4) m_out = rd;
            m_flag = (m_flag & ~clr) | rise;
            m_lvl = nl;
            m_sw2 = m_sw1; m_sw1 = sw;
            m_b2 = m_b1; m_b1 = btn;
        end
    end

    // Every-cycle comparison, away from the active edge
    always @(negedge clk) begin
        vectors++;
        if (portout !== m_out) begin
            miscompares++;
            $display("FAIL portout t=%0t got %h want %h",
                     $time, portout, m_out);
        end
        vectors++;
        if (btn_level !== m_lvl) begin
            miscompares++;
            $display("FAIL btn_level t=%0t got %h want %h",
                     $time, btn_level, m_lvl);
        end
    end

    task automatic chk(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %h want %h",
                     name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic rd(input logic [15:0] a);
        portaddr = a;
        portget = 1'b1;
        tick();
        portget = 1'b0;
    endtask

    logic [15:0] atab [8];

    initial begin
        atab[0] = 16'h000F; atab[1] = 16'h0010;
        atab[2] = 16'h0011; atab[3] = 16'h0012;
        atab[4] = 16'h0013; atab[5] = 16'h0014;
        atab[6] = 16'h0020; atab[7] = 16'hFFFF;

        ticks(2);
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("reset_portout", portout, 16'h0000);
        chk("reset_level", {12'h0, btn_level}, 16'h0000);

        sw = 8'hA5;
        ticks(3);
        rd(16'h0010);
        @(negedge clk);
        chk("sw_read", portout, 16'h00A5);
        rd(16'h0020);
        @(negedge clk);
        chk("unmapped_hold", portout, 16'h00A5);

        btn = 4'b0100;
        ticks(8);
        rd(16'h0011);
        @(negedge clk);
        chk("level_read", portout, 16'h0004);
        rd(16'h0012);
        @(negedge clk);
        chk("flag_read", portout, 16'h0004);
        rd(16'h0012);
        @(negedge clk);
        chk("flag_reread", portout, 16'h0000);

        btn = 4'b0000;
        ticks(8);
        btn = 4'b0001; tick();
        btn = 4'b0000; tick();
        btn = 4'b0001;
        ticks(5);
        @(negedge clk);
        chk("bounce_early", {15'h0, btn_level[0]}, 16'h0000);
        tick();
        @(negedge clk);
        chk("bounce_rise", {15'h0, btn_level[0]}, 16'h0001);
        rd(16'h0012);
        @(negedge clk);
        chk("bounce_one_flag", portout, 16'h0001);

        btn = 4'b0011; ticks(8);
        btn = 4'b0010; ticks(8);
        btn = 4'b0011; ticks(8);
        btn = 4'b0010; ticks(8);
        btn = 4'b0011;
        ticks(5);
        portaddr = 16'h0012;
        portval = 16'h0003;
        portset = 1'b1;
        tick();
        portset = 1'b0;
        @(negedge clk);
        chk("race_level", {12'h0, btn_level}, 16'h0003);
        rd(16'h0012);
        @(negedge clk);
        chk("race_flags", portout, 16'h0001);

        btn = 4'hF;
        ticks(8);
        rd(16'h0011);
        @(negedge clk);
        chk("pre_reset_level", portout, 16'h000F);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_portout", portout, 16'h0000);
        chk("async_level", {12'h0, btn_level}, 16'h0000);
        tick();
        rst = 1'b0;
        ticks(5);
        @(negedge clk);
        chk("post_reset_early", {12'h0, btn_level}, 16'h0000);
        tick();
        @(negedge clk);
        chk("post_reset_level", {12'h0, btn_level}, 16'h000F);
        rd(16'h0012);
        @(negedge clk);
        chk("post_reset_flags", portout, 16'h000F);

        btn = 4'h0;
        ticks(8);
        for (int n = 0; n < 3000; n++) begin
            int op;
            int ai;
            if ($urandom_range(0, 5) == 0)
                btn = btn ^ 4'($urandom_range(1, 15));
            if ($urandom_range(0, 15) == 0)
                sw = 8'($urandom);
            op = $urandom_range(0, 3);
            ai = $urandom_range(0, 7);
            portaddr = (ai == 7) ? 16'($urandom) : atab[ai];
            portval = 16'($urandom);
            portget = (op == 1 || op == 3);
            portset = (op == 2 || op == 3);
            tick();
        end
        portget = 1'b0;
        portset = 1'b0;

        btn = 4'h0;
        ticks(8);
        rd(16'h0013);
        for (int n = 0; n < 75; n++) begin
            btn = 4'hF; ticks(7);
            btn = 4'h0; ticks(7);
        end
        rd(16'h0013);
        @(negedge clk);
`ifdef PORT_INPUT_EVENT_COUNT_EN
        chk("evt_saturate", portout, 16'h00FF);
`else
        chk("evt_absent", portout, 16'h0000);
`endif
        rd(16'h0013);
        @(negedge clk);
        chk("evt_cleared", portout, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/port_input.md
# port_input

Memory-mapped input stage for the CPU port bus: synchronises and debounces the board buttons and switches, latches button-press events, and returns the selected value on `portout` in response to `portget`. It sits beside the output-port latch in the machine top level, on the same `portaddr`/`portget`/`portset` bus driven by the cpu. It replaces direct wiring of raw switch and button pins.

## Interface
- `WORD_SIZE`, 16, port data and address width.
- `DEBOUNCE_BITS`, 16, debounce counter width; a button must be stable for 2^DEBOUNCE_BITS synchronised cycles.
- `BASE_ADDR`, 16'h0010, first of four consecutive port addresses owned by this block.
- `clk` input 1: the single clock for the block.
- `rst` input 1: reset, asynchronous and active-high.
- `sw` input 8: raw switches, asynchronous.
- `btn` input 4: raw buttons, asynchronous, active-high.
- `portaddr` input WORD_SIZE: port address from the cpu.
- `portval` input WORD_SIZE: port write data from the cpu.
- `portget` input 1: one-cycle read strobe.
- `portset` input 1: one-cycle write strobe.
- `portout` output WORD_SIZE: registered read data.
- `btn_level` output 4: debounced button levels, for LEDs.

## Operation
- Synchronisers: two-flop synchroniser on every `sw` and `btn` bit. Switches are not debounced.
- Debounce, per button: counter `cnt[i]` of width DEBOUNCE_BITS.
  - If the synchronised input equals `btn_level[i]`, `cnt` clears.
  - Otherwise `cnt` increments.
  - If the input differs while `cnt` is all-ones, `btn_level[i]` toggles and `cnt` clears.
- Events: a 0→1 transition of `btn_level[i]` sets sticky `flag[i]`.
- Port map, offset from BASE_ADDR, full-width compare:
  - +0: read returns `{0, sw_sync}`.
  - +1: read returns `{0, btn_level}`.
  - +2: read returns `{0, flag}` and clears every flag reported as 1. A write clears each `flag[i]` where `portval[i]`=1.
  - +3: read returns the event counter; see Configuration.
- Any other address: the block ignores reads and writes and leaves `portout` unchanged.
- Writes to +0, +1 and +3 are ignored.
- Same-cycle conflict: a new rising edge beats a clear, so the flag stays 1.
- `portget` and `portset` asserted together: the read is serviced and the write is ignored.

## Timing
- Reset values: `portout`=0, `btn_level`=0, all flags 0, all `cnt` 0, synchroniser flops 0, event counter 0.
- Read latency: `portout` is updated on the clock edge that samples `portget`, so it is valid the cycle after the strobe. It holds until the next serviced read.
- Read-clear: a flag cleared by a read is 0 from the cycle after the strobe.
- Button latency: pin change to `btn_level` change is 2 sync cycles plus 2^DEBOUNCE_BITS cycles of stability. Any bounce restarts the count.
- Flag latency: the flag is set on the same edge on which `btn_level` rises.
- Reset mid-debounce: the partial count is lost, and the pin must be stable for the full window again after `rst` falls.

## Configuration
- `PORT_INPUT_EVENT_COUNT_EN` defined: an 8-bit counter at +3 increments by the number of simultaneous button rising edges (0–4) and saturates at 255.
  - A read at +3 returns `{0, count}` and clears the counter to 0 in that cycle.
  - If edges occur in the same cycle as the read-clear, the counter becomes the number of edges.
- Not defined: no counter logic exists, and a read at +3 returns 0.

## Test plan
All scenarios use DEBOUNCE_BITS=2, BASE_ADDR=16'h0010.
- Reset: assert `rst` asynchronously with `btn`=4'hF → `portout`=0, `btn_level`=0, flags 0 immediately. Release `rst` → `btn_level`=4'hF after 2+4 cycles.
- Bounce: `btn[0]` toggles 1,0,1 on alternate cycles, then holds 1 → `btn_level[0]` rises only 6 cycles after the final 1. Exactly one `flag[0]` set.
- Read/clear: press `btn[2]`, `portget` at 16'h0012 → next cycle `portout`=16'h0004. A second read returns 16'h0000.
- Write-clear race: flags=4'b0011, `portset` at 16'h0012 with `portval`=16'h0003, in the same cycle as `btn_level[0]` rising → flags become 4'b0001.
- Switches and unmapped: `sw`=8'hA5, read 16'h0010 → 16'h00A5 after 3 cycles of setup. Read 16'h0020 → `portout` keeps 16'h00A5.
- With `PORT_INPUT_EVENT_COUNT_EN`: 300 presses, read 16'h0013 → 16'h00FF, then read → 16'h0000. Without the macro: read 16'h0013 → 16'h0000.
